reshuffler_port_joiner: RTL and testbench
=========================================

RESHUFFLER_PORT_JOINER -- requirements
Module: reshuffler_port_joiner

Interface
REQ-001 SHALL have parameter SpatPar, default 8, number of narrow input ports.
REQ-002 SHALL have parameter DataWidth, default 64, bits per input port.
REQ-003 SHALL have parameter Depth, default 2, per-port FIFO entries; power of two, >=2.
REQ-004 SHALL have port clk_i  in  1  clock, rising edge.
REQ-005 SHALL have port rst_ni  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port p_data_i  in  SpatPar*DataWidth  port k occupies bits [k*DataWidth +: DataWidth].
REQ-007 SHALL have port p_valid_i  in  SpatPar  per-port valid.
REQ-008 SHALL have port p_ready_o  out  SpatPar  per-port ready.
REQ-009 SHALL have port a_o  out  SpatPar*DataWidth  joined wide word, feeds reshuffler a_i.
REQ-010 SHALL have port a_valid_o  out  1  wide word valid.
REQ-011 SHALL have port a_ready_i  in  1  downstream ready.
REQ-012 SHALL have port csr_port_mask_i  in  SpatPar  bit k=1 enables port k.
REQ-013 SHALL have port csr_valid_i  in  1  config valid.
REQ-014 SHALL have port csr_ready_o  out  1  config ready.
REQ-015 SHALL have port stall_cycles_o  out  32  join-stall counter (see Configuration).

Function
REQ-016 SHALL hold one FIFO of Depth x DataWidth per port; push on p_valid_i[k] && p_ready_o[k].
REQ-017 SHALL drive p_ready_o[k] = mask[k] && !full[k]; full-and-pop in same cycle gives no ready (no pass-through).
REQ-018 SHALL drive p_ready_o[k] = 0 for masked-off ports; their data/valid is ignored.
REQ-019 SHALL assert a_valid_o when every enabled FIFO is non-empty and mask != 0; masked-off ports never block.
REQ-020 SHALL drive slice k of a_o from FIFO k head when enabled, else zeros.
REQ-021 SHALL pop all enabled FIFOs together on a_valid_o && a_ready_i, only then.
REQ-022 SHALL hold a_o and a_valid_o stable while a_valid_o && !a_ready_i.
REQ-023 SHALL have latency 1 cycle: a word pushed at edge N is visible at a_o no earlier than after edge N.
REQ-024 SHALL sustain one wide word per cycle when all ports and downstream stream continuously (Depth>=2).
REQ-025 SHALL allow simultaneous push and pop on a non-full FIFO, occupancy unchanged.
REQ-026 SHALL wrap read/write pointers modulo Depth with a separate occupancy counter 0..Depth.
REQ-027 SHALL assert csr_ready_o only when all FIFOs are empty; on csr handshake, mask updates next edge.
REQ-028 SHALL deassert a_valid_o when mask = 0 regardless of FIFO state.

Reset
REQ-029 SHALL on rst_ni low: all FIFOs empty, pointers 0, mask = all ones, stall counter 0.
REQ-030 SHALL hold outputs in reset: a_valid_o 0, a_o 0, p_ready_o all ones, csr_ready_o 1, stall_cycles_o 0.
REQ-031 SHALL discard in-flight FIFO contents on reset mid-operation; no word emitted after release until new pushes.

Configuration
REQ-032 SHALL compile stall counter only when macro RESHUFFLER_JOINER_PERF_EN is defined.
REQ-033 SHALL with macro: increment stall_cycles_o each cycle some enabled FIFO non-empty and a_valid_o = 0; saturate at 0xFFFFFFFF; clear on csr handshake.
REQ-034 SHALL without macro: keep port stall_cycles_o, tied to 0, no counter flops.

Verification
REQ-035 SHALL test: ports 0..7 push 0x10..0x17 same cycle, a_ready_i=1 -> next cycle a_valid_o=1, slice k = 0x10+k, single pop.
REQ-036 SHALL test: port 3 pushes 4 cycles after others -> a_valid_o stays 0 until cycle after port 3 push; with macro stall_cycles_o = 4.
REQ-037 SHALL test: a_ready_i=0, all ports push 3 beats -> each p_ready_o drops after 2 beats; data held; release -> beats emitted in order, no loss.
REQ-038 SHALL test: csr mask 0x0F while FIFOs empty -> slices 4..7 = 0, p_ready_o[7:4] = 0, join uses ports 0..3 only.
REQ-039 SHALL test: csr_valid_i with one FIFO non-empty -> csr_ready_o=0, mask unchanged until drained.
REQ-040 SHALL test: rst_ni pulsed low with FIFOs half full -> a_valid_o=0, all empty, no stale word after release.

Source files
------------

// File: rtl/reshuffler_port_joiner.sv
// reshuffler_port_joiner
// Joins SpatPar narrow streams into one wide word for the reshuffler a_i input.
// Each port has its own Depth-entry FIFO. The wide word is valid once every
// enabled FIFO holds a word, and all enabled FIFOs pop together.
//
// Handshake semantics: a transfer happens on a rising clk_i edge where both
// valid and ready are high. Valid never waits on ready. Once a_valid_o is
// raised, a_o and a_valid_o hold until a_ready_i is seen.
// p_ready_o and csr_ready_o depend only on registered state.
//
// Optional feature: define RESHUFFLER_JOINER_PERF_EN to build the join-stall
// counter on stall_cycles_o. Without it, the port reads 0 and no counter is built.
module reshuffler_port_joiner #(
  parameter int unsigned SpatPar   = 8,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [SpatPar*DataWidth-1:0]   p_data_i,
  input  logic [SpatPar-1:0]             p_valid_i,
  output logic [SpatPar-1:0]             p_ready_o,
  output logic [SpatPar*DataWidth-1:0]   a_o,
  output logic                           a_valid_o,
  input  logic                           a_ready_i,
  input  logic [SpatPar-1:0]             csr_port_mask_i,
  input  logic                           csr_valid_i,
  output logic                           csr_ready_o,
  output logic [31:0]                    stall_cycles_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [SpatPar-1:0] mask_q, mask_d;
  logic [SpatPar-1:0] full, empty, push, pop;
  logic               a_valid;
  logic               csr_hs;

  // The mask may only change when nothing is buffered.
  // This keeps every queued word aligned with the mask it was accepted under.
  assign csr_ready_o = &empty;
  assign csr_hs      = csr_valid_i && csr_ready_o;

  // Next mask: take the new configuration on a csr handshake
  always_comb begin
    mask_d = mask_q;
    if (csr_hs) mask_d = csr_port_mask_i;
  end

  // Mask register; after reset every port is enabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mask_q <= '1;
    else         mask_q <= mask_d;
  end

  // Ready is based on occupancy alone, with no pass-through.
  // A full FIFO stays unready even in a cycle where it pops.
  assign p_ready_o = mask_q & ~full;
  assign push      = p_valid_i & p_ready_o;

  // Join: every enabled FIFO holds a word. Disabled ports count as satisfied.
  assign a_valid   = (|mask_q) && (&(~empty | ~mask_q));
  assign a_valid_o = a_valid;
  assign pop       = {SpatPar{a_valid && a_ready_i}} & mask_q;

  for (genvar k = 0; k < SpatPar; k++) begin : g_port
    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    assign full[k]  = (cnt_q == CntW'(Depth));
    assign empty[k] = (cnt_q == '0);

    // Pointer and occupancy update. Depth is a power of two,
    // so each pointer wraps by plain overflow.
    always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push[k]) wptr_d = wptr_q + PtrW'(1);
      if (pop[k])  rptr_d = rptr_q + PtrW'(1);
      case ({push[k], pop[k]})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    // FIFO control state. Reset drops anything still queued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        cnt_q  <= cnt_d;
      end
    end

    // Storage write. Reset is not needed because empty FIFOs never expose the array.
    always_ff @(posedge clk_i) begin
      if (push[k]) mem_q[wptr_q] <= p_data_i[k*DataWidth +: DataWidth];
    end

    // Present the head word for enabled, non-empty ports; zeros otherwise
    assign a_o[k*DataWidth +: DataWidth] =
      (mask_q[k] && !empty[k]) ? mem_q[rptr_q] : '0;
  end

`ifdef RESHUFFLER_JOINER_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Count cycles where some enabled port waits on a slower one.
  // The count saturates, and a csr handshake clears it.
  always_comb begin
    stall_d = stall_q;
    if (csr_hs) begin
      stall_d = '0;
    end else if ((|(~empty & mask_q)) && !a_valid && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_reshuffler_port_joiner.sv
// Directed bench for reshuffler_port_joiner (SpatPar=8, DataWidth=64, Depth=2).
module tb_reshuffler_port_joiner;

  localparam int unsigned SP = 8;
  localparam int unsigned DW = 64;
  localparam int unsigned W  = SP * DW;

  logic          clk_i;
  logic          rst_ni;
  logic [W-1:0]  p_data_i;
  logic [SP-1:0] p_valid_i;
  logic [SP-1:0] p_ready_o;
  logic [W-1:0]  a_o;
  logic          a_valid_o;
  logic          a_ready_i;
  logic [SP-1:0] csr_port_mask_i;
  logic          csr_valid_i;
  logic          csr_ready_o;
  logic [31:0]   stall_cycles_o;

  int n_cmp;
  int n_bad;

  reshuffler_port_joiner #(.SpatPar(SP), .DataWidth(DW), .Depth(2)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .p_data_i        (p_data_i),
    .p_valid_i       (p_valid_i),
    .p_ready_o       (p_ready_o),
    .a_o             (a_o),
    .a_valid_o       (a_valid_o),
    .a_ready_i       (a_ready_i),
    .csr_port_mask_i (csr_port_mask_i),
    .csr_valid_i     (csr_valid_i),
    .csr_ready_o     (csr_ready_o),
    .stall_cycles_o  (stall_cycles_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  // Build a wide word: slice k = base + k where sel[k], else 0
  function automatic logic [W-1:0] mk(input logic [DW-1:0] base, input logic [SP-1:0] sel);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < SP; k++)
      if (sel[k]) r[k*DW +: DW] = base + DW'(k);
    return r;
  endfunction

  // Advance one clock edge; inputs/outputs are handled 1ns after the edge
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; p_data_i = '0; p_valid_i = '0; a_ready_i = 1'b0;
    csr_port_mask_i = '0; csr_valid_i = 1'b0;
    tick; tick;
    n_cmp++; if (a_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_a_valid: got %b exp 0", a_valid_o); end
    n_cmp++; if (a_o !== '0) begin n_bad++; $display("FAIL rst_a_o: got %h exp 0", a_o); end
    n_cmp++; if (p_ready_o !== 8'hFF) begin n_bad++; $display("FAIL rst_p_ready: got %h exp ff", p_ready_o); end
    n_cmp++; if (csr_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_csr_ready: got %b exp 1", csr_ready_o); end
    n_cmp++; if (stall_cycles_o !== 32'd0) begin n_bad++; $display("FAIL rst_stall: got %0d exp 0", stall_cycles_o); end
    rst_ni = 1'b1;
    tick;
  endtask

  task automatic test_join_all;
    logic [W-1:0] exp_w;
    exp_w = mk(64'h10, 8'hFF);
    a_ready_i = 1'b1; p_data_i = exp_w; p_valid_i = 8'hFF;
    n_cmp++; if (a_valid_o !== 1'b0) begin n_bad++; $display("FAIL join_pre_valid: got %b exp 0", a_valid_o); end
    tick;
    p_valid_i = '0;
    n_cmp++; if (a_valid_o !== 1'b1) begin n_bad++; $display("FAIL join_valid: got %b exp 1", a_valid_o); end
    n_cmp++; if (a_o !== exp_w) begin n_bad++; $display("FAIL join_data: got %h exp %h", a_o, exp_w); end
    tick;
    n_cmp++; if (a_valid_o !== 1'b0) begin n_bad++; $display("FAIL join_single_pop: got %b exp 0", a_valid_o); end
    n_cmp++; if (csr_ready_o !== 1'b1) begin n_bad++; $display("FAIL join_drained: got %b exp 1", csr_ready_o); end
  endtask

  task automatic test_stall;
    logic [W-1:0] exp_w;
    logic [31:0]  exp_stall;
`ifdef RESHUFFLER_JOINER_PERF_EN
    exp_stall = 32'd4;
`else
    exp_stall = 32'd0;
`endif
    exp_w = mk(64'h20, 8'hFF);
    a_ready_i = 1'b1; p_data_i = exp_w; p_valid_i = 8'hF7;
    tick;
    p_valid_i = '0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (a_valid_o !== 1'b0) begin n_bad++; $display("FAIL stall_wait_%0d: got %b exp 0", i, a_valid_o); end
      tick;
    end
    n_cmp++; if (a_valid_o !== 1'b0) begin n_bad++; $display("FAIL stall_wait_3: got %b exp 0", a_valid_o); end
    p_valid_i = 8'h08;
    tick;
    p_valid_i = '0;
    n_cmp++; if (a_valid_o !== 1'b1) begin n_bad++; $display("FAIL stall_join: got %b exp 1", a_valid_o); end
    n_cmp++; if (a_o !== exp_w) begin n_bad++; $display("FAIL stall_data: got %h exp %h", a_o, exp_w); end
    n_cmp++; if (stall_cycles_o !== exp_stall) begin n_bad++; $display("FAIL stall_count: got %0d exp %0d", stall_cycles_o, exp_stall); end
    tick;
    n_cmp++; if (a_valid_o !== 1'b0) begin n_bad++; $display("FAIL stall_pop: got %b exp 0", a_valid_o); end
    n_cmp++; if (stall_cycles_o !== exp_stall) begin n_bad++; $display("FAIL stall_count_hold: got %0d exp %0d", stall_cycles_o, exp_stall); end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] b0, b1, b2;
    b0 = mk(64'h100, 8'hFF); b1 = mk(64'h200, 8'hFF); b2 = mk(64'h300, 8'hFF);
    a_ready_i = 1'b0; p_valid_i = 8'hFF; p_data_i = b0;
    tick;
    p_data_i = b1;
    tick;
    n_cmp++; if (p_ready_o !== 8'h00) begin n_bad++; $display("FAIL bp_full: got %h exp 00", p_ready_o); end
    n_cmp++; if (a_o !== b0) begin n_bad++; $display("FAIL bp_head: got %h exp %h", a_o, b0); end
    p_data_i = b2;
    tick;
    n_cmp++; if (p_ready_o !== 8'h00) begin n_bad++; $display("FAIL bp_still_full: got %h exp 00", p_ready_o); end
    n_cmp++; if (a_valid_o !== 1'b1 || a_o !== b0) begin n_bad++; $display("FAIL bp_hold: got v=%b %h exp v=1 %h", a_valid_o, a_o, b0); end
    a_ready_i = 1'b1;
    tick;
    n_cmp++; if (a_o !== b1) begin n_bad++; $display("FAIL bp_beat1: got %h exp %h", a_o, b1); end
    n_cmp++; if (p_ready_o !== 8'hFF) begin n_bad++; $display("FAIL bp_ready_back: got %h exp ff", p_ready_o); end
    tick;
    p_valid_i = '0;
    n_cmp++; if (a_valid_o !== 1'b1 || a_o !== b2) begin n_bad++; $display("FAIL bp_beat2: got v=%b %h exp v=1 %h", a_valid_o, a_o, b2); end
    tick;
    n_cmp++; if (a_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b exp 0", a_valid_o); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] w;
    a_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = mk(DW'(64'h1000 * (i + 1)), 8'hFF);
      exp_q.push_back(w);
      p_data_i = w; p_valid_i = 8'hFF;
      tick;
      w = exp_q.pop_front();
      n_cmp++; if (a_valid_o !== 1'b1 || a_o !== w) begin n_bad++; $display("FAIL b2b_beat%0d: got v=%b %h exp v=1 %h", i, a_valid_o, a_o, w); end
      n_cmp++; if (p_ready_o !== 8'hFF) begin n_bad++; $display("FAIL b2b_ready%0d: got %h exp ff", i, p_ready_o); end
    end
    p_valid_i = '0;
    tick;
    n_cmp++; if (a_valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got %b exp 0", a_valid_o); end
  endtask

  task automatic test_mask;
    logic [W-1:0] exp_w;
    csr_port_mask_i = 8'h0F; csr_valid_i = 1'b1;
    n_cmp++; if (csr_ready_o !== 1'b1) begin n_bad++; $display("FAIL mask_csr_ready: got %b exp 1", csr_ready_o); end
    tick;
    csr_valid_i = 1'b0;
    n_cmp++; if (p_ready_o !== 8'h0F) begin n_bad++; $display("FAIL mask_p_ready: got %h exp 0f", p_ready_o); end
    a_ready_i = 1'b0; p_data_i = mk(64'h30, 8'hFF); p_valid_i = 8'hFF;
    exp_w = mk(64'h30, 8'h0F);
    tick;
    p_valid_i = '0;
    n_cmp++; if (a_valid_o !== 1'b1) begin n_bad++; $display("FAIL mask_valid: got %b exp 1", a_valid_o); end
    n_cmp++; if (a_o !== exp_w) begin n_bad++; $display("FAIL mask_data: got %h exp %h", a_o, exp_w); end
    n_cmp++; if (p_ready_o !== 8'h0F) begin n_bad++; $display("FAIL mask_p_ready2: got %h exp 0f", p_ready_o); end
    a_ready_i = 1'b1;
    tick;
    n_cmp++; if (a_valid_o !== 1'b0 || csr_ready_o !== 1'b1) begin n_bad++; $display("FAIL mask_drain: got v=%b csr=%b exp v=0 csr=1", a_valid_o, csr_ready_o); end
  endtask

  task automatic test_csr_blocked;
    a_ready_i = 1'b1; p_data_i = mk(64'h40, 8'hFF); p_valid_i = 8'h01;
    tick;
    p_valid_i = '0;
    n_cmp++; if (csr_ready_o !== 1'b0) begin n_bad++; $display("FAIL csrb_ready: got %b exp 0", csr_ready_o); end
    csr_port_mask_i = 8'hFF; csr_valid_i = 1'b1;
    tick;
    n_cmp++; if (p_ready_o !== 8'h0F) begin n_bad++; $display("FAIL csrb_mask_held: got %h exp 0f", p_ready_o); end
    n_cmp++; if (csr_ready_o !== 1'b0) begin n_bad++; $display("FAIL csrb_ready2: got %b exp 0", csr_ready_o); end
    p_valid_i = 8'h0E;
    tick;
    p_valid_i = '0;
    n_cmp++; if (a_valid_o !== 1'b1 || a_o !== mk(64'h40, 8'h0F)) begin n_bad++; $display("FAIL csrb_join: got v=%b %h", a_valid_o, a_o); end
    tick;
    n_cmp++; if (csr_ready_o !== 1'b1 || p_ready_o !== 8'h0F) begin n_bad++; $display("FAIL csrb_drained: got csr=%b rdy=%h exp csr=1 rdy=0f", csr_ready_o, p_ready_o); end
    tick;
    csr_valid_i = 1'b0;
    n_cmp++; if (p_ready_o !== 8'hFF) begin n_bad++; $display("FAIL csrb_mask_new: got %h exp ff", p_ready_o); end
  endtask

  task automatic test_reset_mid;
    a_ready_i = 1'b0; p_data_i = mk(64'h50, 8'hFF); p_valid_i = 8'hFF;
    tick;
    p_valid_i = '0;
    n_cmp++; if (a_valid_o !== 1'b1) begin n_bad++; $display("FAIL rmid_pre: got %b exp 1", a_valid_o); end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (a_valid_o !== 1'b0 || a_o !== '0) begin n_bad++; $display("FAIL rmid_async: got v=%b %h exp v=0 0", a_valid_o, a_o); end
    n_cmp++; if (csr_ready_o !== 1'b1 || p_ready_o !== 8'hFF) begin n_bad++; $display("FAIL rmid_empty: got csr=%b rdy=%h", csr_ready_o, p_ready_o); end
    tick;
    rst_ni = 1'b1; a_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (a_valid_o !== 1'b0 || a_o !== '0) begin n_bad++; $display("FAIL rmid_stale%0d: got v=%b %h exp v=0 0", i, a_valid_o, a_o); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset;
    test_join_all;
    test_stall;
    test_backpressure;
    test_back_to_back;
    test_mask;
    test_csr_blocked;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
